i2c_master: RTL and testbench

//  Single-byte I2C bus initiator: the counterpart to the team's i2c_slave.
//  On a start request it issues START, the 7-bit address plus R/W bit, and one data byte
//  (written, or read and NACKed), then STOP.

---
 rtl/i2c_pkg.sv | 18 +
 rtl/i2c_bit_timer.sv | 38 +++
 rtl/i2c_master.sv | 147 ++++++++++++++
 tb/tb_i2c_master.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the bus initiator and target: FSM states, ACK levels, quarter indices.
// No logic, no latency.
// No flow control.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, AACK, WDATA, WACK, RDATA, RNACK, STOP, DONE
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

endpackage

// File: rtl/i2c_bit_timer.sv
// SCL quarter-period timebase: counter 0..QTR_DIV-1 plus quarter index, with qtr_end/sample strobes.
// Strobes are combinational from the counter; cleared to q0/count 0 whenever run is low.
// hold freezes the count (slave clock stretching); no other backpressure.
module i2c_bit_timer
  #(parameter int QTR_DIV = 125,
    parameter int CNT_W   = 8)
  (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       hold,
    output logic [1:0] q,
    output logic       qtr_end,
    output logic       sample
  );
  import i2c_pkg::*;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QTR_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign qtr_end = run && !hold && (cnt == CNT_LAST);
  // SDA is read on the last clk of the second high quarter, just before SCL falls.
  assign sample  = qtr_end && (q == Q2);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
      q   <= Q0;
    end else if (qtr_end) begin
      cnt <= '0;
      q   <= q + 2'd1;
    end else if (!hold) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C initiator: START, {addr,rw}, one data byte (write, or read then NACK), STOP.
// Latency: 80 quarter-periods start->done (44 on address NACK), plus any stretched clocks.
// start ignored while busy; I2C_CLK_STRETCH_EN adds scl_in so a slave can hold SCL low in q1/q2.
module i2c_master
  #(parameter int QTR_DIV = 125,
    parameter int CNT_W   = 8)
  (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    input  logic       sda_in,
`ifdef I2C_CLK_STRETCH_EN
    input  logic       scl_in,
`endif
    output logic       scl,
    output logic       sda_out,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
  );
  import i2c_pkg::*;

  state_t     state, state_nxt;
  logic [1:0] q;
  logic       run, hold, qtr_end, sample, slot_end, last_bit, accept, bit_scl;
  logic [2:0] bit_cnt;
  logic [7:0] sreg, wdata_r;
  logic       rw_r, ack_smp;

  assign run      = (state != IDLE) && (state != DONE);
  assign accept   = start && (state == IDLE);
  assign slot_end = qtr_end && (q == Q3);
  assign last_bit = slot_end && (bit_cnt == 3'd7);
  assign bit_scl  = (q == Q1) || (q == Q2);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

`ifdef I2C_CLK_STRETCH_EN
  assign hold = bit_scl && !scl_in;
`else
  assign hold = 1'b0;
`endif

  i2c_bit_timer #(.QTR_DIV(QTR_DIV), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .hold    (hold),
    .q       (q),
    .qtr_end (qtr_end),
    .sample  (sample)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      sreg    <= '0;
      wdata_r <= '0;
      rw_r    <= 1'b0;
      ack_smp <= I2C_ACK;
      ack_err <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sreg    <= {addr, rw};
        wdata_r <= wdata;
        rw_r    <= rw;
        bit_cnt <= '0;
        ack_err <= 1'b0;
      end
      if (sample) begin
        ack_smp <= sda_in;
        if (state == RDATA) sreg <= {sreg[6:0], sda_in};
      end
      // Shifting at slot end keeps SDA edges inside the SCL-low window.
      if (slot_end) begin
        case (state)
          ADDR, WDATA: begin
            sreg    <= {sreg[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          RDATA: bit_cnt <= bit_cnt + 3'd1;
          AACK: begin
            sreg <= wdata_r;
            if (ack_smp != I2C_ACK) ack_err <= 1'b1;
          end
          WACK:  if (ack_smp != I2C_ACK) ack_err <= 1'b1;
          RNACK: rdata <= sreg;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt = state;
    scl       = 1'b1;
    sda_out   = 1'b1;
    case (state)
      IDLE:  if (start) state_nxt = START;
      START: begin
        sda_out = (q == Q0) || (q == Q1);
        if (slot_end) state_nxt = ADDR;
      end
      ADDR: begin
        scl     = bit_scl;
        sda_out = sreg[7];
        if (last_bit) state_nxt = AACK;
      end
      AACK: begin
        scl = bit_scl;
        if (slot_end) state_nxt = (ack_smp == I2C_NACK) ? STOP : (rw_r ? RDATA : WDATA);
      end
      WDATA: begin
        scl     = bit_scl;
        sda_out = sreg[7];
        if (last_bit) state_nxt = WACK;
      end
      WACK: begin
        scl = bit_scl;
        if (slot_end) state_nxt = STOP;
      end
      RDATA: begin
        scl = bit_scl;
        if (last_bit) state_nxt = RNACK;
      end
      RNACK: begin
        scl = bit_scl;
        if (slot_end) state_nxt = STOP;
      end
      STOP: begin
        scl     = (q != Q0);
        sda_out = (q == Q2) || (q == Q3);
        if (slot_end) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: bus-level model of the quarter-period waveform plus a simple slave responder.
module tb_i2c_master;

  localparam int QTR = 4;

  logic       clk, rst, start, rw, sda_in, scl_in;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       scl, sda_out, busy, done, ack_err;

  int total = 0;
  int bad   = 0;
  int nprint = 0;
  int edge_n = 0;
  logic chk_en = 1'b0;

  // slave plan for the transaction in flight
  logic       pl_aack = 1'b0, pl_wack = 1'b0;
  logic [7:0] pl_rbyte = 8'h00;

  // behavioural model state
  logic       m_busy = 1'b0, m_rw = 1'b0, m_nak = 1'b0, m_err = 1'b0, m_fin_err = 1'b0;
  logic [7:0] m_a8 = 8'h00, m_wd = 8'h00, m_rdata = 8'h00, m_fin_rd = 8'h00;
  int         m_n = 0, m_len = 0;

  i2c_master #(.QTR_DIV(QTR), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .addr    (addr),
    .rw      (rw),
    .wdata   (wdata),
    .sda_in  (sda_in),
`ifdef I2C_CLK_STRETCH_EN
    .scl_in  (scl_in),
`endif
    .scl     (scl),
    .sda_out (sda_out),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err),
    .rdata   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Expected {scl,sda} for quarter k of a transaction, straight from the bus rules.
  function automatic logic [1:0] exp_bus(int k, logic [7:0] a8, logic [7:0] wd, logic r, logic nak);
    int s, p;
    logic mid;
    s = k / 4;
    p = k % 4;
    mid = (p == 1) || (p == 2);
    if (s == 0) return {1'b1, (p < 2) ? 1'b1 : 1'b0};
    if (s == (nak ? 10 : 19)) return {(p != 0) ? 1'b1 : 1'b0, (p >= 2) ? 1'b1 : 1'b0};
    if (s >= 1 && s <= 8) return {mid, a8[8-s]};
    if (s >= 10 && s <= 17 && !r) return {mid, wd[17-s]};
    return {mid, 1'b1};
  endfunction

  // Transaction-level model: elapsed clocks since accept, frozen while a slave stretches SCL.
  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_n     <= 0;
      m_err   <= 1'b0;
      m_rdata <= 8'h00;
    end else if (!m_busy) begin
      if (start) begin
        m_busy    <= 1'b1;
        m_n       <= 0;
        m_a8      <= {addr, rw};
        m_wd      <= wdata;
        m_rw      <= rw;
        m_nak     <= pl_aack;
        m_len     <= pl_aack ? 44 : 80;
        m_fin_err <= pl_aack | (!rw & pl_wack);
        m_fin_rd  <= (rw && !pl_aack) ? pl_rbyte : m_rdata;
      end
    end else if (m_n == m_len * QTR) begin
      m_busy  <= 1'b0;
      m_err   <= m_fin_err;
      m_rdata <= m_fin_rd;
    end else if (!(!scl_in && (((m_n / QTR) % 4 == 1) || ((m_n / QTR) % 4 == 2)))) begin
      m_n <= m_n + 1;
    end
  end

  // Slave responder: holds each response bit for its whole slot.
  always_comb begin
    int s;
    s = (m_n / QTR) / 4;
    sda_in = 1'b1;
    if (m_busy) begin
      if (s == 9) sda_in = pl_aack;
      else if (m_rw && !m_nak && s >= 10 && s <= 17) sda_in = pl_rbyte[17-s];
      else if (!m_rw && !m_nak && s == 18) sda_in = pl_wack;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [1:0] eb;
    logic ed, ebz;
    if (chk_en) begin
      if (!m_busy) begin
        eb = 2'b11; ed = 1'b0; ebz = 1'b0;
      end else if (m_n == m_len * QTR) begin
        eb = 2'b11; ed = 1'b1; ebz = 1'b1;
      end else begin
        eb = exp_bus(m_n / QTR, m_a8, m_wd, m_rw, m_nak); ed = 1'b0; ebz = 1'b1;
      end
      total++;
      if ({scl, sda_out, busy, done} !== {eb, ebz, ed}) begin
        bad++;
        if (nprint < 10)
          $display("FAIL bus t=%0t {scl,sda,busy,done} got=%b%b%b%b want=%b%b%b%b",
                   $time, scl, sda_out, busy, done, eb[1], eb[0], ebz, ed);
        nprint++;
      end
      if (!m_busy || ed) begin
        total++;
        if ({ack_err, rdata} !== (ed ? {m_fin_err, m_fin_rd} : {m_err, m_rdata})) begin
          bad++;
          if (nprint < 10)
            $display("FAIL status t=%0t ack_err/rdata got=%b/%h want=%b/%h", $time, ack_err, rdata,
                     ed ? m_fin_err : m_err, ed ? m_fin_rd : m_rdata);
          nprint++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Drives one transaction; captures SDA at each SCL rising edge and the done latency.
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] wd,
                         input logic an, input logic wn, input logic [7:0] rb,
                         input int poke_n, input int rst_at, input int st_at, input int st_len,
                         output int lat, output logic [17:0] cap, output int ndone);
    int acc, nr;
    logic prev_scl;
    pl_aack = an; pl_wack = wn; pl_rbyte = rb;
    addr = a; rw = r; wdata = wd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc = edge_n;
    lat = -1; cap = '0; nr = 0; ndone = 0; prev_scl = scl;
    for (int n = 0; n < 80 * QTR + st_len + 40; n++) begin
      if (scl && !prev_scl && nr < 18) begin
        cap = {cap[16:0], sda_out};
        nr++;
      end
      prev_scl = scl;
      if (done) begin
        ndone++;
        if (lat < 0) lat = edge_n - acc;
      end
      if (rst_at >= 0 && n == rst_at + 1) begin
        chk("rst_mid_scl", 32'(scl), 32'd1);
        chk("rst_mid_sda", 32'(sda_out), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
      end
      start = (n == poke_n) || (done && poke_n >= 0);
      rst = (n == rst_at);
      if (n == st_at) scl_in = 1'b0;
      if (n == st_at + st_len) scl_in = 1'b1;
      @(negedge clk);
    end
    start = 1'b0; rst = 1'b0; scl_in = 1'b1;
  endtask

  int lat, nd;
  logic [17:0] cap;

  initial begin
    rst = 1'b1; start = 1'b0; addr = '0; rw = 1'b0; wdata = '0; scl_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'h00);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // write with ACKs
    run_txn(7'h51, 1'b0, 8'hAE, 1'b0, 1'b0, 8'h00, -1, -1, -1, 0, lat, cap, nd);
    chk("wr_latency", 32'(lat), 32'(80 * QTR));
    chk("wr_bits", 32'(cap), 32'({8'hA2, 1'b1, 8'hAE, 1'b1}));
    chk("wr_ack_err", 32'(ack_err), 32'd0);
    chk("wr_ndone", 32'(nd), 32'd1);

    // read returning 8'h3C
    run_txn(7'h51, 1'b1, 8'h00, 1'b0, 1'b0, 8'h3C, -1, -1, -1, 0, lat, cap, nd);
    chk("rd_rdata", 32'(rdata), 32'h3C);
    chk("rd_bits", 32'(cap), 32'({8'hA3, 1'b1, 8'hFF, 1'b1}));
    chk("rd_latency", 32'(lat), 32'(80 * QTR));
    chk("rd_ack_err", 32'(ack_err), 32'd0);

    // address NACK
    run_txn(7'h22, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, -1, -1, -1, 0, lat, cap, nd);
    chk("nak_latency", 32'(lat), 32'(44 * QTR));
    chk("nak_ack_err", 32'(ack_err), 32'd1);
    chk("nak_rdata", 32'(rdata), 32'h3C);

    // start while busy and in the done cycle
    run_txn(7'h13, 1'b0, 8'h77, 1'b0, 1'b0, 8'h00, 100, -1, -1, 0, lat, cap, nd);
    chk("poke_ndone", 32'(nd), 32'd1);
    chk("poke_busy", 32'(busy), 32'd0);
    chk("poke_ack_err", 32'(ack_err), 32'd0);

    // reset during WDATA bit 3, then a normal transfer
    run_txn(7'h51, 1'b0, 8'hC3, 1'b0, 1'b0, 8'h00, -1, 53 * QTR, -1, 0, lat, cap, nd);
    chk("rst_ndone", 32'(nd), 32'd0);
    run_txn(7'h51, 1'b0, 8'hAE, 1'b0, 1'b1, 8'h00, -1, -1, -1, 0, lat, cap, nd);
    chk("after_rst_latency", 32'(lat), 32'(80 * QTR));
    chk("after_rst_wack_err", 32'(ack_err), 32'd1);

`ifdef I2C_CLK_STRETCH_EN
    run_txn(7'h51, 1'b0, 8'hAE, 1'b0, 1'b0, 8'h00, -1, -1, 5 * QTR, 300, lat, cap, nd);
    chk("stretch_latency", 32'(lat), 32'(80 * QTR + 300));
    chk("stretch_bits", 32'(cap), 32'({8'hA2, 1'b1, 8'hAE, 1'b1}));
`endif

    for (int i = 0; i < 25; i++) begin
      logic an, wn, r;
      int poke, sat, slen, base;
      an = ($urandom_range(0, 3) == 0);
      wn = ($urandom_range(0, 3) == 0);
      r = 1'(($urandom_range(0, 1)));
      poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 150)) : -1;
      sat = -1;
      slen = 0;
`ifdef I2C_CLK_STRETCH_EN
      if ($urandom_range(0, 1) == 1) begin
        sat = (4 * int'($urandom_range(1, 8)) + 1) * QTR;
        slen = int'($urandom_range(1, 40));
      end
`endif
      run_txn(7'($urandom), r, 8'($urandom), an, wn, 8'($urandom), poke, -1, sat, slen, lat, cap, nd);
      base = an ? 44 : 80;
      chk("rand_latency", 32'(lat), 32'(base * QTR + slen));
      chk("rand_ndone", 32'(nd), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
